// File: rtl/max_unpool_if.sv
// Pooled-input / unpooled-output bundle for max_unpool.
// master = producer/consumer side, slave = the unpool block.
interface max_unpool_if #(
  parameter int DW = 16
);
  logic          load;
  logic [DW-1:0] in_data;
  logic [2:0]    history;
  logic          in_ready;
  logic [DW-1:0] result;
  logic [5:0]    addr;
  logic          out_valid;
  logic          out_ready;
  logic          done;
  logic          err;

  modport master (
    output load, in_data, history, out_ready,
    input  in_ready, result, addr, out_valid, done, err
  );

  modport slave (
    input  load, in_data, history, out_ready,
    output in_ready, result, addr, out_valid, done, err
  );
endinterface

// File: rtl/max_unpool.sv
// 2x2 max-unpool: buffers one pooled frame with argmax codes,
// then streams the SIZE x SIZE map in raster order.
module max_unpool #(
  parameter int SIZE = 6,
  parameter int DW   = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  max_unpool_if.slave  bus
);
  localparam int N  = SIZE / 2;
  localparam int NE = N * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam int RW = $clog2(SIZE);

  typedef enum logic [1:0] {
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] col_q, col_d;
  logic          err_q, err_d;

  logic [DW-1:0] val_q  [NE];
  logic [2:0]    hist_q [NE];

  logic          accept;
  logic          ohs;
  logic          last_in;
  logic          col_end;
  logic          last_out;
  logic [IW-1:0] rd_idx;
  logic          match;

  assign accept   = (state_q == S_LOAD) && bus.load;
  assign ohs      = (state_q == S_EMIT) && bus.out_ready;
  assign last_in  = wr_idx_q == IW'(NE - 1);
  assign col_end  = col_q == RW'(SIZE - 1);
  assign last_out = col_end && (row_q == RW'(SIZE - 1));

  assign rd_idx = IW'(int'(row_q >> 1) * N
                    + int'(col_q >> 1));
  // Codes 4..7 have bit 2 set and so never match a cell.
  assign match  = hist_q[rd_idx]
               == {1'b0, row_q[0], col_q[0]};

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    row_d    = row_q;
    col_d    = col_q;
    err_d    = err_q;
    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (bus.history[2]) err_d = 1'b1;
          if (last_in) begin
            wr_idx_d = '0;
            row_d    = '0;
            col_d    = '0;
            state_d  = S_EMIT;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (ohs) begin
          if (last_out) begin
            row_d   = '0;
            col_d   = '0;
            state_d = S_DONE;
          end else if (col_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        row_d   = '0;
        col_d   = '0;
        state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_LOAD;
      wr_idx_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      val_q[wr_idx_q]  <= bus.in_data;
      hist_q[wr_idx_q] <= bus.history;
    end
  end

  assign bus.in_ready  = state_q == S_LOAD;
  assign bus.out_valid = state_q == S_EMIT;
  assign bus.done      = state_q == S_DONE;
  assign bus.err       = err_q;
  assign bus.addr      = bus.out_valid
    ? 6'(int'(row_q) * SIZE + int'(col_q))
    : 6'd0;
  assign bus.result    = (bus.out_valid && match)
    ? val_q[rd_idx] : '0;
endmodule
